// File: rtl/cordic_polar_decim.sv
// cordic_polar_decim: block averager for CORDIC vectoring-mode output.
// Each block of 2^k samples becomes one magnitude/phase pair. Phase is
// accumulated as signed offsets from the block's first sample, so a cluster
// that straddles the 0/360 degree seam still averages to the right angle.
module cordic_polar_decim #(
  parameter int WIDTH    = 18,
  parameter int MAX_LOG2 = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] mag_i,
  input  logic [WIDTH:0]   phase_i,
  input  logic [3:0]       decim_log2_i,
  input  logic             sync_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] mag_o,
  output logic [WIDTH:0]   phase_o
);

  localparam int WP  = WIDTH + 1;             // phase width
  localparam int MSW = WIDTH + MAX_LOG2;      // magnitude accumulator width
  localparam int PSW = WIDTH + 1 + MAX_LOG2;  // phase-offset accumulator width
  localparam int CW  = MAX_LOG2 + 1;          // sample counter must reach 2^MAX_LOG2
  localparam logic [3:0] KMAX = 4'(MAX_LOG2);

  typedef enum logic {IDLE, ACC} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              k_q, k_d;
  logic [WP-1:0]           base_q, base_d;
  logic [MSW-1:0]          mag_sum_q, mag_sum_d;
  logic signed [PSW-1:0]   ph_sum_q, ph_sum_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic [WIDTH-1:0]        mag_q, mag_d;
  logic [WP-1:0]           phase_q, phase_d;

  logic                    start;
  logic                    done;
  logic [3:0]              k_req;
  logic signed [WP-1:0]    diff;

  // Floor average of the unsigned magnitude sum.
  function automatic logic [WIDTH-1:0] avg_mag(input logic [MSW-1:0] sum,
                                               input logic [3:0] k);
    return WIDTH'(sum >> k);
  endfunction

  // Mean offset (floored toward -inf) added back to the block's reference
  // phase; truncation to WP bits gives the modulo-360 wrap.
  function automatic logic [WP-1:0] avg_phase(input logic [WP-1:0] base_ph,
                                              input logic signed [PSW-1:0] sum,
                                              input logic [3:0] k);
    logic signed [PSW-1:0] mean;
    mean = sum >>> k;
    return WP'(PSW'(base_ph) + mean);
  endfunction

  // Next-state logic: block start, accumulation, sync discard and completion.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    mag_sum_d = mag_sum_q;
    ph_sum_d  = ph_sum_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    mag_d     = mag_q;
    phase_d   = phase_q;
    done      = 1'b0;
    // Offset from the reference, wrapped into the signed +/-180 degree range.
    diff      = phase_i - base_q;
    k_req     = (decim_log2_i > KMAX) ? KMAX : decim_log2_i;
    // A sample arriving with sync always opens a fresh block.
    start     = valid_i && ((state_q == IDLE) || sync_i);

    if (start) begin
      k_d       = k_req;
      base_d    = phase_i;
      mag_sum_d = MSW'(mag_i);
      ph_sum_d  = '0;
      cnt_d     = CW'(1);
      done      = (k_req == 4'd0);
      state_d   = done ? IDLE : ACC;
    end else if (sync_i) begin
      state_d   = IDLE;
      mag_sum_d = '0;
      ph_sum_d  = '0;
      cnt_d     = '0;
    end else if (valid_i) begin
      mag_sum_d = mag_sum_q + MSW'(mag_i);
      ph_sum_d  = ph_sum_q + PSW'(diff);
      cnt_d     = cnt_q + CW'(1);
      done      = (cnt_d == (CW'(1) << k_q));
      if (done) state_d = IDLE;
    end

    if (done) begin
      valid_d = 1'b1;
      mag_d   = avg_mag(mag_sum_d, k_d);
      phase_d = avg_phase(base_d, ph_sum_d, k_d);
    end
  end

  // State, accumulators and registered outputs; all cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      base_q    <= '0;
      mag_sum_q <= '0;
      ph_sum_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      mag_q     <= '0;
      phase_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      base_q    <= base_d;
      mag_sum_q <= mag_sum_d;
      ph_sum_q  <= ph_sum_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      mag_q     <= mag_d;
      phase_q   <= phase_d;
    end
  end

  assign valid_o = valid_q;
  assign mag_o   = mag_q;
  assign phase_o = phase_q;

endmodule

// File: tb/tb_cordic_polar_decim.sv
// Testbench for cordic_polar_decim: directed scenarios plus randomized
// traffic, checked against a block-level averaging model.
module tb_cordic_polar_decim;

  localparam int  W  = 18;
  localparam longint PM = longint'(1) << (W + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  mag_i = '0;
  logic [W:0]    phase_i = '0;
  logic [3:0]    decim_log2_i = '0;
  logic          sync_i = 1'b0;
  logic          valid_o;
  logic [W-1:0]  mag_o;
  logic [W:0]    phase_o;

  cordic_polar_decim #(.WIDTH(W), .MAX_LOG2(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mag_i(mag_i),
    .phase_i(phase_i), .decim_log2_i(decim_log2_i), .sync_i(sync_i),
    .valid_o(valid_o), .mag_o(mag_o), .phase_o(phase_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] m;
    logic [W:0]   p;
    logic [31:0]  c;
  } res_t;

  res_t expq[$];
  res_t obsq[$];
  int checks = 0;
  int passed = 0;
  logic [W-1:0] last_m = '0;
  logic [W:0]   last_p = '0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && valid_o) begin
      obsq.push_back('{m: mag_o, p: phase_o, c: 32'(cyc)});
      last_m = mag_o;
      last_p = phase_o;
    end
  end

  // Reference model: collect the block's samples, then average them.
  bit     in_blk = 0;
  int     blk_k = 0;
  longint bm[$];
  longint bp[$];

  task automatic model_clear();
    in_blk = 0;
    bm.delete();
    bp.delete();
  endtask

  task automatic model_step(bit v, logic [W-1:0] m, logic [W:0] p, logic [3:0] k, bit s);
    longint msum, osum, base, d, q, n, t;
    if (s && !v) model_clear();
    if (v) begin
      if (!in_blk || s) begin
        model_clear();
        blk_k = (k > 4'd8) ? 8 : int'(k);
        in_blk = 1;
      end
      bm.push_back(longint'(m));
      bp.push_back(longint'(p));
      n = longint'(1) << blk_k;
      if (longint'(bm.size()) == n) begin
        msum = 0;
        osum = 0;
        base = bp[0];
        foreach (bm[i]) begin
          msum += bm[i];
          d = bp[i] - base;
          if (d < 0) d += PM;
          if (d >= PM / 2) d -= PM;
          osum += d;
        end
        q = osum / n;
        if ((osum % n != 0) && (osum < 0)) q -= 1;
        t = (base + q) % PM;
        if (t < 0) t += PM;
        expq.push_back('{m: W'(msum / n), p: (W+1)'(t), c: 32'(cyc + 1)});
        model_clear();
      end
    end
  endtask

  // Present one cycle of input (accepted at the next rising edge).
  task automatic drive(bit v, logic [W-1:0] m, logic [W:0] p, logic [3:0] k, bit s);
    @(posedge clk);
    #1;
    valid_i = v; mag_i = m; phase_i = p; decim_log2_i = k; sync_i = s;
    model_step(v, m, p, k, s);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, decim_log2_i, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid_o); else passed++;
    checks++;
    if (mag_o !== '0) $display("FAIL reset_mag: got %0d want 0", mag_o); else passed++;
    checks++;
    if (phase_o !== '0) $display("FAIL reset_phase: got %0d want 0", phase_o); else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    for (int i = 0; i < 4; i++) drive(1, 18'd1000, 19'h10000, 4'd2, 0);
    idle(3);
    checks++;
    if (obsq.size() != expq.size()) $display("FAIL const_count: got %0d want %0d", obsq.size(), expq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL const_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    checks++;
    if (last_m !== 18'd1000 || last_p !== 19'h10000) $display("FAIL const_value: got m=%0d p=%0d want m=1000 p=65536", last_m, last_p); else passed++;
    obsq.delete(); expq.delete();
  endtask

  task automatic test_phase_wrap();
    drive(1, 18'd100, 19'd524286, 4'd2, 0);
    drive(1, 18'd101, 19'd524287, 4'd2, 0);
    drive(1, 18'd102, 19'd0, 4'd2, 0);
    drive(1, 18'd103, 19'd1, 4'd2, 0);
    idle(3);
    checks++;
    if (obsq.size() != expq.size()) $display("FAIL wrap_count: got %0d want %0d", obsq.size(), expq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL wrap_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    checks++;
    if (last_m !== 18'd101 || last_p !== 19'd524287) $display("FAIL wrap_value: got m=%0d p=%0d want m=101 p=524287", last_m, last_p); else passed++;
    obsq.delete(); expq.delete();
  endtask

  task automatic test_passthrough();
    drive(1, 18'd5, 19'd7, 4'd0, 0);
    drive(1, 18'd9, 19'd3, 4'd0, 0);
    idle(3);
    checks++;
    if (obsq.size() != 2 || expq.size() != 2) $display("FAIL pass_count: got %0d want 2", obsq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL pass_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_sync();
    for (int i = 0; i < 5; i++) drive(1, 18'd50, 19'(1000 + i), 4'd3, 0);
    drive(1, 18'd50, 19'd2000, 4'd3, 1);
    for (int i = 0; i < 7; i++) drive(1, 18'd50, 19'(2001 + i), 4'd3, 0);
    idle(2);
    // sync without a sample drops a partial block silently
    for (int i = 0; i < 3; i++) drive(1, 18'd77, 19'd5, 4'd2, 0);
    drive(0, '0, '0, 4'd2, 1);
    idle(4);
    checks++;
    if (obsq.size() != 1 || expq.size() != 1) $display("FAIL sync_count: got %0d want 1", obsq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL sync_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_decim_change();
    drive(1, 18'd10, 19'd100, 4'd2, 0);
    drive(1, 18'd20, 19'd104, 4'd2, 0);
    drive(1, 18'd30, 19'd108, 4'd1, 0);
    drive(1, 18'd41, 19'd111, 4'd1, 0);
    drive(1, 18'd60, 19'd300, 4'd1, 0);
    drive(1, 18'd71, 19'd299, 4'd1, 0);
    idle(3);
    checks++;
    if (obsq.size() != 2 || expq.size() != 2) $display("FAIL kchg_count: got %0d want 2", obsq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL kchg_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_reset_mid();
    drive(1, 18'd999, 19'd50, 4'd2, 0);
    drive(1, 18'd999, 19'd50, 4'd2, 0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || mag_o !== '0 || phase_o !== '0) $display("FAIL rstmid_outputs: got v=%0b m=%0d p=%0d want 0 0 0", valid_o, mag_o, phase_o); else passed++;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1, 18'd200, 19'(7000 + i), 4'd2, 0);
    idle(3);
    checks++;
    if (obsq.size() != 1 || expq.size() != 1) $display("FAIL rstmid_count: got %0d want 1", obsq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL rstmid_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    checks++;
    if (last_m !== 18'd200) $display("FAIL rstmid_mag: got %0d want 200", last_m); else passed++;
    obsq.delete(); expq.delete();
  endtask

  task automatic test_max_decim();
    // request above the supported maximum; blocks clamp to 256 samples
    for (int i = 0; i < 256; i++)
      drive(1, (i < 128) ? 18'h3FFFF : 18'($urandom), 19'($urandom), 4'd15, 0);
    idle(3);
    checks++;
    if (obsq.size() != 1 || expq.size() != 1) $display("FAIL maxk_count: got %0d want 1", obsq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL maxk_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    obsq.delete(); expq.delete();
  endtask

  task automatic test_random();
    logic [W:0] center;
    bit v, s;
    logic [3:0] k;
    center = 19'($urandom);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) center = 19'($urandom);
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 59) == 0);
      k = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      drive(v, 18'($urandom), 19'(longint'(center) + longint'($urandom_range(0, 131070)) - 65535), k, s);
    end
    drive(0, '0, '0, 4'd0, 1);
    idle(3);
    checks++;
    if (obsq.size() != expq.size()) $display("FAIL rand_count: got %0d want %0d", obsq.size(), expq.size()); else passed++;
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) $display("FAIL rand_result[%0d]: got m=%0d p=%0d c=%0d want m=%0d p=%0d c=%0d", i, obsq[i].m, obsq[i].p, obsq[i].c, expq[i].m, expq[i].p, expq[i].c); else passed++;
    end
    obsq.delete(); expq.delete();
  endtask

  initial begin
    test_reset();
    test_constant();
    test_phase_wrap();
    test_passthrough();
    test_sync();
    test_decim_change();
    test_reset_mid();
    test_max_decim();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
